// File: rtl/ay_bus_seq.sv
// ay_bus_seq: multi-chip AY-3-8910/YM2149 bus sequencer.
// Turns one host request (chip, register, data, op) into a timed
// BDIR/BC1/BC2 command sequence (latch address, then write or read), with a
// per-chip latched-register cache that skips redundant address phases.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req, op, chip,       host request; accepted when req=1 and busy=0
//   reg_num, wdata       (op: 00 write, 01 read, 10/11 latch-only)
//   cache_clr            synchronous invalidate of all cache entries
//   bdir, bc1, bc2       per-chip AY bus control (bc2 tied high)
//   da_out, da_oe, da_in shared DA bus drive / enable / read value
//   rd_data              captured read data
//   busy, done, err      status; err qualifies done for a bad chip index
module ay_bus_seq #(
   parameter int unsigned NCHIP     = 2,
   parameter int unsigned LATCH_CYC = 2,
   parameter int unsigned WRITE_CYC = 3,
   parameter int unsigned READ_CYC  = 3,
   parameter int unsigned GAP_CYC   = 1,
   parameter int unsigned CACHE_EN  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic [1:0]       op,
   input  logic [1:0]       chip,
   input  logic [3:0]       reg_num,
   input  logic [7:0]       wdata,
   input  logic             cache_clr,
   output logic [NCHIP-1:0] bdir,
   output logic [NCHIP-1:0] bc1,
   output logic             bc2,
   output logic [7:0]       da_out,
   output logic             da_oe,
   input  logic [7:0]       da_in,
   output logic [7:0]       rd_data,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned CW = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LATCH = 3'd1;
   localparam logic [2:0] S_GAP_A = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_READ  = 3'd4;
   localparam logic [2:0] S_GAP_B = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [1:0] OP_WR = 2'b00;
   localparam logic [1:0] OP_RD = 2'b01;

   localparam logic [CW-1:0] LATCH_LD = CW'(LATCH_CYC - 1);
   localparam logic [CW-1:0] WRITE_LD = CW'(WRITE_CYC - 1);
   localparam logic [CW-1:0] READ_LD  = CW'(READ_CYC - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

   logic [2:0]       state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [1:0]       op_q, chip_q;
   logic [3:0]       reg_q;
   logic [7:0]       wdata_q;
   logic [1:0]       op_n, chip_n;
   logic [3:0]       reg_n;
   logic [7:0]       wdata_n;
   logic [3:0]       cache_vld;
   logic [3:0][3:0]  cache_tag;
   logic             accept, bad_chip, hit, last;
   logic [3:0]       sel_oh;
   logic [NCHIP-1:0] bdir_n, bc1_n;
   logic [7:0]       da_out_n;
   logic             da_oe_n, busy_n, done_n, err_n;

   assign bc2      = 1'b1;
   assign accept   = req && (state == S_IDLE);
   assign bad_chip = 32'(chip) >= NCHIP;
   assign last     = (cnt == '0);
   // A clear coinciding with the accept makes the entry look invalid.
   assign hit      = (CACHE_EN != 0) && !cache_clr && cache_vld[chip] &&
                     (cache_tag[chip] == reg_num) && ((op == OP_WR) || (op == OP_RD));

   // Next-state and phase counter.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (bad_chip) begin
                  state_n = S_DONE;
               end else if (hit) begin
                  state_n = (op == OP_WR) ? S_WRITE : S_READ;
                  cnt_n   = (op == OP_WR) ? WRITE_LD : READ_LD;
               end else begin
                  state_n = S_LATCH;
                  cnt_n   = LATCH_LD;
               end
            end
         end
         S_LATCH: begin
            if (last) begin
               state_n = S_GAP_A;
               cnt_n   = GAP_LD;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_GAP_A: begin
            if (last) begin
               if (op_q == OP_WR) begin
                  state_n = S_WRITE;
                  cnt_n   = WRITE_LD;
               end else if (op_q == OP_RD) begin
                  state_n = S_READ;
                  cnt_n   = READ_LD;
               end else begin
                  state_n = S_DONE;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_WRITE: begin
            if (last) begin
               state_n = S_GAP_B;
               cnt_n   = GAP_LD;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_GAP_B: begin
            if (last) state_n = S_DONE;
            else      cnt_n   = cnt - CW'(1);
         end
         S_READ: begin
            if (last) state_n = S_DONE;
            else      cnt_n   = cnt - CW'(1);
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Next output values, decoded from the state being entered.
   always_comb begin
      op_n     = accept ? op      : op_q;
      chip_n   = accept ? chip    : chip_q;
      reg_n    = accept ? reg_num : reg_q;
      wdata_n  = accept ? wdata   : wdata_q;
      sel_oh   = 4'b0001 << chip_n;
      bdir_n   = '0;
      bc1_n    = '0;
      da_out_n = da_out;
      da_oe_n  = da_oe;
      busy_n   = (state_n != S_IDLE);
      done_n   = (state_n == S_DONE);
      err_n    = 1'b0;
      case (state_n)
         S_LATCH: begin
            bdir_n   = sel_oh[NCHIP-1:0];
            bc1_n    = sel_oh[NCHIP-1:0];
            da_out_n = {4'h0, reg_n};
            da_oe_n  = 1'b1;
         end
         S_WRITE: begin
            bdir_n   = sel_oh[NCHIP-1:0];
            da_out_n = wdata_n;
            da_oe_n  = 1'b1;
         end
         S_READ: begin
            bc1_n   = sel_oh[NCHIP-1:0];
            da_oe_n = 1'b0;
         end
         S_DONE: begin
            da_oe_n = 1'b0;
            err_n   = err | (accept & bad_chip);
         end
         S_IDLE:  da_oe_n = 1'b0;
         default: ; // gap phases hold the DA bus
      endcase
   end

   // State, request capture and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op_q    <= '0;
         chip_q  <= '0;
         reg_q   <= '0;
         wdata_q <= '0;
         bdir    <= '0;
         bc1     <= '0;
         da_out  <= '0;
         da_oe   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rd_data <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         op_q    <= op_n;
         chip_q  <= chip_n;
         reg_q   <= reg_n;
         wdata_q <= wdata_n;
         bdir    <= bdir_n;
         bc1     <= bc1_n;
         da_out  <= da_out_n;
         da_oe   <= da_oe_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
         if ((state == S_READ) && last) rd_data <= da_in;
      end
   end

   // Latched-register cache; the LATCH-exit write overrides a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_vld <= '0;
         cache_tag <= '0;
      end else begin
         if (cache_clr) cache_vld <= '0;
         if ((state == S_LATCH) && last) begin
            cache_vld[chip_q] <= 1'b1;
            cache_tag[chip_q] <= reg_q;
         end
      end
   end

endmodule
